// File: rtl/serial_sub_ctrl_if.sv
// Handshake and data bundle between a requester and the bit-serial subtract sequencer.
// The requester drives start and the operands; the sequencer returns status and result.
interface serial_sub_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             zero;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow_out, zero
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow_out, zero
    );
endinterface

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: one bit per clock, LSB first, through a full-subtract stage
// built from two half-subtractor cells and a borrow flop. Result registers update once per operation.
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_sub_ctrl_if.slave   bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic             bin_q, bin_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             zero_q, zero_d;

    logic             d1, br1, d_bit, br2, borrow_new;
    logic [WIDTH-1:0] work_shift;

    // Two cascaded half-subtractors form the full-subtract stage on the current LSBs.
    always_comb begin
        d1         = sa_q[0] ^ sb_q[0];
        br1        = ~sa_q[0] & sb_q[0];
        d_bit      = d1 ^ bin_q;
        br2        = ~d1 & bin_q;
        borrow_new = br1 | br2;
        work_shift = (work_q >> 1) | (WIDTH'(d_bit) << (WIDTH - 1));
    end

    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        work_d   = work_q;
        bin_d    = bin_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        zero_d   = zero_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    sa_d    = bus.a;
                    sb_d    = bus.b;
                    bin_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                work_d = work_shift;
                sa_d   = sa_q >> 1;
                sb_d   = sb_q >> 1;
                bin_d  = borrow_new;
                cnt_d  = cnt_q + CNT_W'(1);
                // The last bit's edge publishes the result directly from the shifter.
                if (cnt_q == LAST) begin
                    diff_d   = work_shift;
                    borrow_d = borrow_new;
                    zero_d   = (work_shift == '0);
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            work_q   <= '0;
            bin_q    <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            work_q   <= work_d;
            bin_q    <= bin_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            zero_q   <= zero_d;
        end
    end

    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.done       = (state_q == ST_DONE);
    assign bus.diff       = diff_q;
    assign bus.borrow_out = borrow_q;
    assign bus.zero       = zero_q;
endmodule
